bist_engine: RTL
================

// Module: bist_engine
// PURPOSE
//  Parametrised BIST engine that drives a scan-inserted circuit under test (CUT).
//  Generates pseudo-random stimulus with an LFSR and sequences scan shift/capture.
//  Compacts scan and primary outputs in a MISR, then compares against a golden
//  signature to produce bist_end and pass_fail. Sits between the top-level pins
//  and the CUT; in functional mode it is transparent to the CUT inputs.
// PARAMETERS
//  N_IN        3      CUT primary inputs driven by the engine
//  N_OUT       3      CUT primary outputs compacted
//  LFSR_W      8      LFSR width; must be > N_IN
//  LFSR_TAPS   8'hB8  feedback tap mask (bit i set = lfsr[i] in XOR)
//  LFSR_SEED   8'h01  seed loaded in INIT; a seed of 0 is replaced by 1
//  MISR_W      8      MISR width; must be >= N_OUT+1
//  MISR_TAPS   8'hB8  MISR feedback tap mask
//  SCAN_LEN    4      scan chain length (shift cycles per pattern), >= 1
//  N_PATTERNS  8      patterns applied, >= 1
//  GOLDEN      8'h00  expected final MISR signature
// PORTS
//  CLK         in   1        clock, all state updates on rising edge
//  RST         in   1        asynchronous reset, active-low
//  bist_start  in   1        level request to start/restart a BIST run
//  bist_abort  in   1        abandon run, return to IDLE
//  func_in     in   N_IN     functional CUT inputs
//  dut_out     in   N_OUT    CUT primary outputs
//  scan_out    in   1        CUT scan chain output
//  dut_in      out  N_IN     CUT inputs: func_in when not running, else lfsr[N_IN-1:0]
//  scan_en     out  1        CUT scan enable (1 = shift, 0 = capture/functional)
//  scan_in     out  1        CUT scan chain input = lfsr[N_IN]
//  bist_running out 1        high in INIT/RUN/FLUSH/COMPARE
//  bist_end    out  1        high in DONE
//  pass_fail   out  1        valid when bist_end=1; 1 = signature == GOLDEN
//  signature   out  MISR_W   current MISR contents
// BEHAVIOUR
//  Reset (RST=0, any time incl. mid-run): state=IDLE, lfsr=LFSR_SEED, misr=0,
//   counters=0, scan_en=0, bist_running=0, bist_end=0, pass_fail=0.
//  FSM: IDLE -> INIT when bist_start=1. INIT (1 cycle): load seed, clear misr.
//   RUN: per pattern, SCAN_LEN cycles with scan_en=1, then 1 capture cycle with
//   scan_en=0; after N_PATTERNS patterns -> FLUSH. FLUSH: SCAN_LEN cycles with
//   scan_en=1 to unload the last response -> COMPARE (1 cycle, scan_en=0):
//   pass_fail <= (misr == GOLDEN) -> DONE. DONE holds bist_end, pass_fail and
//   signature; bist_start=1 in DONE -> INIT (restart).
//  bist_start is ignored in INIT/RUN/FLUSH/COMPARE.
//  bist_abort=1 in INIT/RUN/FLUSH/COMPARE -> IDLE next edge, bist_end stays 0,
//   pass_fail=0. bist_abort has priority over bist_start in IDLE/DONE (stay/go IDLE).
//  LFSR advances every RUN/FLUSH cycle: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr&LFSR_TAPS)}.
//  MISR updates every RUN/FLUSH cycle: misr <= {misr[MISR_W-2:0],
//   ^(misr&MISR_TAPS)} ^ zero-extended {dut_out, scan_out}. Holds otherwise.
//  Edge count: leaving IDLE at edge E0, DONE is entered at E0+2+N_PATTERNS*
//   (SCAN_LEN+1)+SCAN_LEN (defaults: E0+46).
//  dut_in/scan_in mux is combinational on state; scan_en, bist_* registered.
// TESTING
//  1 Reset mid-RUN: drop RST at cycle 20 -> all outputs 0 async, IDLE; dut_in=func_in.
//  2 Functional: idle, func_in=3'b101 -> dut_in=3'b101, scan_en=0, bist_end=0.
//  3 LFSR: defaults, start -> lfsr in successive RUN cycles 01,02,04,08,11; scan_en
//    pattern 1111 0 repeated 8x, then 1111 FLUSH.
//  4 Timing: start at E0 -> bist_end rises at E0+46; pass_fail=1 when GOLDEN = model sig.
//  5 Fault: force dut_out[0]=0 throughout -> signature != GOLDEN, pass_fail=0.
//  6 Abort at RUN cycle 10 -> IDLE next edge, bist_end=0; restart -> same signature as 4.

Source files
------------

// File: rtl/bist_if.sv
// Pin-side and CUT-side signals of the BIST engine, bundled for one connection.
// The engine takes the slave view; the environment or top level takes the master view.
interface bist_if #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 3,
    parameter int MISR_W = 8
) ();
    logic              bist_start;
    logic              bist_abort;
    logic [N_IN-1:0]   func_in;
    logic [N_OUT-1:0]  dut_out;
    logic              scan_out;
    logic [N_IN-1:0]   dut_in;
    logic              scan_en;
    logic              scan_in;
    logic              bist_running;
    logic              bist_end;
    logic              pass_fail;
    logic [MISR_W-1:0] signature;

    modport master (
        output bist_start, bist_abort, func_in, dut_out, scan_out,
        input  dut_in, scan_en, scan_in, bist_running, bist_end, pass_fail, signature
    );

    modport slave (
        input  bist_start, bist_abort, func_in, dut_out, scan_out,
        output dut_in, scan_en, scan_in, bist_running, bist_end, pass_fail, signature
    );
endinterface

// File: rtl/bist_engine.sv
// Logic BIST engine: LFSR stimulus, scan shift/capture sequencing, MISR compaction
// of scan and primary outputs, and a final compare against a golden signature.
module bist_engine #(
    parameter int                N_IN       = 3,
    parameter int                N_OUT      = 3,
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'h01,
    parameter int                MISR_W     = 8,
    parameter logic [MISR_W-1:0] MISR_TAPS  = 8'hB8,
    parameter int                SCAN_LEN   = 4,
    parameter int                N_PATTERNS = 8,
    parameter logic [MISR_W-1:0] GOLDEN     = 8'h00
) (
    input  logic  clk,
    input  logic  rst_n,
    bist_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        COMPARE,
        DONE
    } state_t;

    localparam int PH_W  = (SCAN_LEN   < 1) ? 1 : $clog2(SCAN_LEN + 1);
    localparam int PAT_W = (N_PATTERNS < 2) ? 1 : $clog2(N_PATTERNS + 1);

    localparam logic [PH_W-1:0]   PH_CAPTURE = PH_W'(SCAN_LEN);
    localparam logic [PH_W-1:0]   PH_LAST_SH = PH_W'(SCAN_LEN - 1);
    localparam logic [PAT_W-1:0]  PAT_LAST   = PAT_W'(N_PATTERNS - 1);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [LFSR_W-1:0] SEED       = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    state_t             state_reg;
    logic [LFSR_W-1:0]  lfsr_reg;
    logic [MISR_W-1:0]  misr_reg;
    logic [PH_W-1:0]    ph_reg;
    logic [PAT_W-1:0]   pat_reg;
    logic               scan_en_reg;
    logic               running_reg;
    logic               end_reg;
    logic               pass_reg;

    logic [LFSR_W-1:0]  lfsr_next;
    logic [MISR_W-1:0]  misr_next;
    logic [MISR_W-1:0]  misr_in;
    logic               in_test;

    // MISR input word: scan_out in bit 0, dut_out above it, zero-extended.
    generate
        for (genvar gi = 0; gi < MISR_W; gi++) begin : g_misr_in
            if (gi == 0) begin : g_scan
                assign misr_in[gi] = bus.scan_out;
            end else if (gi <= N_OUT) begin : g_out
                assign misr_in[gi] = bus.dut_out[gi-1];
            end else begin : g_zero
                assign misr_in[gi] = 1'b0;
            end
        end
    endgenerate

    assign lfsr_next = {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
    assign misr_next = {misr_reg[MISR_W-2:0], ^(misr_reg & MISR_TAPS)} ^ misr_in;

    assign in_test = (state_reg == INIT) || (state_reg == RUN) ||
                     (state_reg == FLUSH) || (state_reg == COMPARE);

    // The CUT input mux follows the state directly so functional mode is transparent.
    assign bus.dut_in       = in_test ? lfsr_reg[N_IN-1:0] : bus.func_in;
    assign bus.scan_in      = lfsr_reg[N_IN];
    assign bus.scan_en      = scan_en_reg;
    assign bus.bist_running = running_reg;
    assign bus.bist_end     = end_reg;
    assign bus.pass_fail    = pass_reg;
    assign bus.signature    = misr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            misr_reg    <= '0;
            ph_reg      <= '0;
            pat_reg     <= '0;
            scan_en_reg <= 1'b0;
            running_reg <= 1'b0;
            end_reg     <= 1'b0;
            pass_reg    <= 1'b0;
        end else if (in_test && bus.bist_abort) begin
            state_reg   <= IDLE;
            ph_reg      <= '0;
            pat_reg     <= '0;
            scan_en_reg <= 1'b0;
            running_reg <= 1'b0;
            end_reg     <= 1'b0;
            pass_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.bist_start && !bus.bist_abort) begin
                        state_reg   <= INIT;
                        running_reg <= 1'b1;
                    end
                end

                INIT: begin
                    state_reg   <= RUN;
                    lfsr_reg    <= SEED;
                    misr_reg    <= '0;
                    ph_reg      <= '0;
                    pat_reg     <= '0;
                    scan_en_reg <= 1'b1;
                end

                RUN: begin
                    lfsr_reg <= lfsr_next;
                    misr_reg <= misr_next;
                    if (ph_reg == PH_CAPTURE) begin
                        ph_reg      <= '0;
                        scan_en_reg <= 1'b1;
                        if (pat_reg == PAT_LAST) begin
                            pat_reg   <= '0;
                            state_reg <= FLUSH;
                        end else begin
                            pat_reg <= pat_reg + 1'b1;
                        end
                    end else begin
                        ph_reg      <= ph_reg + 1'b1;
                        // Drop scan_en one cycle early so the capture cycle sees it low.
                        scan_en_reg <= (ph_reg != PH_LAST_SH);
                    end
                end

                FLUSH: begin
                    lfsr_reg <= lfsr_next;
                    misr_reg <= misr_next;
                    if (ph_reg == PH_LAST_SH) begin
                        ph_reg      <= '0;
                        scan_en_reg <= 1'b0;
                        state_reg   <= COMPARE;
                    end else begin
                        ph_reg <= ph_reg + 1'b1;
                    end
                end

                COMPARE: begin
                    pass_reg    <= (misr_reg == GOLDEN);
                    end_reg     <= 1'b1;
                    running_reg <= 1'b0;
                    state_reg   <= DONE;
                end

                DONE: begin
                    if (bus.bist_abort) begin
                        state_reg <= IDLE;
                        end_reg   <= 1'b0;
                        pass_reg  <= 1'b0;
                    end else if (bus.bist_start) begin
                        state_reg   <= INIT;
                        end_reg     <= 1'b0;
                        pass_reg    <= 1'b0;
                        running_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    scan_en_reg <= 1'b0;
                    running_reg <= 1'b0;
                    end_reg     <= 1'b0;
                    pass_reg    <= 1'b0;
                end
            endcase
        end
    end

endmodule
